systolic_operand_feeder: RTL
============================

# systolic_operand_feeder

Upstream feeder for the systolic tile. It holds two 3x3 operand matrices, A and B, whose elements are 8-lane vectors, in a double-buffered store. It emits them as diagonal-skewed streams on the five left and five top array inputs. It also generates the enable / is_row_done / is_compute_done strobes that the convolution collection stage consumes.

## Interface
- MATRIX_SIZE, 3, operand matrix dimension
- ARRAY_SIZE, 2*MATRIX_SIZE-1 (5), number of left ports and number of top ports
- DATA_WIDTH, 16, lane width in bits
- LANES, 8, lanes per element vector
- DRAIN_CYCLES, 9, zero-feed cycles after the feed phase; MATRIX_SIZE+DRAIN_CYCLES must be a multiple of MATRIX_SIZE
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load_valid  in  1  element write request
- load_ready  out  1  shadow bank writable
- load_is_b  in  1  0 = write A, 1 = write B
- load_idx  in  4  row-major element index, 0..8
- load_data  in  [DATA_WIDTH-1:0] x [LANES-1:0]  element vector (unpacked [7:0])
- commit  in  1  marks the shadow bank complete
- input_left0..input_left4  out  [DATA_WIDTH-1:0] x [7:0] each  A diagonal streams
- input_top0..input_top4  out  [DATA_WIDTH-1:0] x [7:0] each  B diagonal streams
- enable, is_row_done, is_compute_done  out  1 each  strobes to the collection stage
- busy  out  1  FSM not IDLE

## Operation
- Storage: two banks, each holding A[3][3] and B[3][3] element vectors.
  - The active bank is read by the FSM; the shadow bank is written by the load port.
  - The shadow_full flag is cleared by reset.
- Load path:
  - load_ready = !shadow_full.
  - A write occurs when load_valid && load_ready.
  - load_idx >= 9 is accepted and dropped.
- Commit: commit with !shadow_full sets shadow_full. Commit while shadow_full is ignored.
  - A write and a commit in the same cycle: the write lands, then shadow_full sets.
- FSM states: IDLE, FEED, DRAIN.
  - IDLE -> FEED when shadow_full: swap banks, clear shadow_full, step=0.
  - FEED: MATRIX_SIZE cycles, step 0..2, then -> DRAIN.
  - DRAIN: DRAIN_CYCLES cycles.
  - On the last DRAIN cycle: if shadow_full, swap banks and go -> FEED (back-to-back, no bubble); else -> IDLE.
- Skew mapping: port p (0..4) carries diagonal d = p-2.
  - Diagonal d holds elements M[r][r+d], with valid r from max(0,-d) to min(2,2-d).
  - At FEED step t, port p emits the t-th element of its diagonal, or all-zero if t >= the diagonal length (lengths 1,2,3,2,1).
  - Left ports use A; top ports use B.
  - Example: input_left2 = A[0][0], A[1][1], A[2][2] at t = 0, 1, 2; input_left4 = A[0][2] at t=0, then zero.
- During DRAIN and IDLE, all stream outputs are zero.
- Strobes:
  - enable = 1 throughout FEED and DRAIN.
  - is_row_done pulses on every MATRIX_SIZE-th enabled cycle (3rd, 6th, 9th, 12th).
  - is_compute_done pulses on the last DRAIN cycle only.
- No arithmetic is performed on data; vectors pass through bit-exact.

## Timing
- All outputs are registered.
- Reset values: all stream lanes 0, enable 0, is_row_done 0, is_compute_done 0, busy 0, load_ready 1. Both banks are cleared and the FSM goes to IDLE.
- Latency: commit sampled at edge E -> shadow_full after E, FSM in FEED after E+1, step-0 data and enable=1 visible after E+2.
- One compute job occupies MATRIX_SIZE+DRAIN_CYCLES = 12 consecutive enable cycles.
- Back-to-back jobs (commit during the previous job): enable stays high continuously. The is_compute_done pulse of job N and step-0 data of job N+1 are on consecutive cycles.
- load_ready drops the cycle after commit and rises the cycle after the swap.
- Reset asserted mid-job: outputs are zero immediately (asynchronous); no done pulse is emitted. After release the FSM is in IDLE and loaded data is lost.

## Test plan
- Reset: assert rst mid-FEED -> all outputs 0 the same cycle, load_ready=1. After release, busy stays 0 with no commit.
- Single job: load A[r][c] lane0 = 10r+c, B = 100+10r+c, then commit. Expected:
  - input_left2 = 0, 11, 22 on steps 0..2.
  - input_top0 = 120, then 0.
  - enable high for 12 cycles; is_row_done on enabled cycles 3, 6, 9, 12; is_compute_done on cycle 12.
- Back-to-back: second set committed during DRAIN -> no enable gap; job 2 step 0 directly follows the job 1 done pulse; job 2 data is from the new set.
- Backpressure: a second commit without a swap -> load_ready=0, writes blocked, extra commit ignored, shadow contents unchanged.
- Boundary writes: load_idx=9..15 are dropped, with no corruption of A[2][2]. A write and commit in the same cycle -> the element is present in the job.
- Lane integrity: distinct values in all 8 lanes -> every lane is reproduced unchanged on the mapped port and step.

Source files
------------

// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder
// Double-buffered A/B operand store (3x3 matrices of 8-lane vectors) that feeds
// the five left and five top edge ports of the systolic tile as diagonal-skewed
// streams, and produces the enable / row-done / compute-done strobes for the
// collection stage.
module systolic_operand_feeder #(
    parameter int unsigned MATRIX_SIZE  = 3,
    parameter int unsigned ARRAY_SIZE   = 2 * MATRIX_SIZE - 1,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned LANES        = 8,
    parameter int unsigned DRAIN_CYCLES = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  load_is_b,
    input  logic [3:0]            load_idx,
    input  logic [DATA_WIDTH-1:0] load_data       [LANES-1:0],
    input  logic                  commit,
    output logic [DATA_WIDTH-1:0] input_left0     [LANES-1:0],
    output logic [DATA_WIDTH-1:0] input_left1     [LANES-1:0],
    output logic [DATA_WIDTH-1:0] input_left2     [LANES-1:0],
    output logic [DATA_WIDTH-1:0] input_left3     [LANES-1:0],
    output logic [DATA_WIDTH-1:0] input_left4     [LANES-1:0],
    output logic [DATA_WIDTH-1:0] input_top0      [LANES-1:0],
    output logic [DATA_WIDTH-1:0] input_top1      [LANES-1:0],
    output logic [DATA_WIDTH-1:0] input_top2      [LANES-1:0],
    output logic [DATA_WIDTH-1:0] input_top3      [LANES-1:0],
    output logic [DATA_WIDTH-1:0] input_top4      [LANES-1:0],
    output logic                  enable,
    output logic                  is_row_done,
    output logic                  is_compute_done,
    output logic                  busy
);

    localparam int unsigned NELEM      = MATRIX_SIZE * MATRIX_SIZE;
    localparam int unsigned JOB_CYCLES = MATRIX_SIZE + DRAIN_CYCLES;
    localparam int unsigned IW         = $clog2(NELEM);
    localparam int unsigned CW         = $clog2(JOB_CYCLES);
    localparam int unsigned RW         = $clog2(MATRIX_SIZE);

    typedef logic [LANES-1:0][DATA_WIDTH-1:0] vec_t;
    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_e;

    state_e        state_q;
    logic          active_q;
    logic          shadow_full_q;
    logic [CW-1:0] cyc_q;
    logic [RW-1:0] row_q;
    logic          busy_q;

    vec_t a_q [2][NELEM];
    vec_t b_q [2][NELEM];

    logic [ARRAY_SIZE-1:0][LANES-1:0][DATA_WIDTH-1:0] left_d;
    logic [ARRAY_SIZE-1:0][LANES-1:0][DATA_WIDTH-1:0] top_d;
    logic [ARRAY_SIZE-1:0][LANES-1:0][DATA_WIDTH-1:0] left_q;
    logic [ARRAY_SIZE-1:0][LANES-1:0][DATA_WIDTH-1:0] top_q;
    logic enable_q;
    logic row_done_q;
    logic done_q;

    vec_t load_vec_c;
    logic shadow_c;
    logic wr_en_c;
    logic commit_c;
    logic job_last_c;
    logic swap_c;

    assign shadow_c   = ~active_q;
    assign wr_en_c    = load_valid && !shadow_full_q && (load_idx < 4'(NELEM));
    assign commit_c   = commit && !shadow_full_q;
    assign job_last_c = (state_q != IDLE) && (cyc_q == CW'(JOB_CYCLES - 1));
    // A committed shadow bank is taken over from IDLE or at the end of a job.
    assign swap_c     = shadow_full_q && ((state_q == IDLE) || job_last_c);

    // Shadow-bank writes and the shadow_full handshake flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q           <= '{default: '0};
            b_q           <= '{default: '0};
            shadow_full_q <= 1'b0;
        end else begin
            if (wr_en_c) begin
                if (load_is_b) begin
                    b_q[shadow_c][IW'(load_idx)] <= load_vec_c;
                end else begin
                    a_q[shadow_c][IW'(load_idx)] <= load_vec_c;
                end
            end
            if (swap_c) begin
                shadow_full_q <= 1'b0;
            end else if (commit_c) begin
                shadow_full_q <= 1'b1;
            end
        end
    end

    // Job sequencer: IDLE -> FEED (MATRIX_SIZE steps) -> DRAIN, chaining jobs without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            cyc_q    <= '0;
            row_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (swap_c) begin
                        state_q  <= FEED;
                        active_q <= ~active_q;
                        cyc_q    <= '0;
                        row_q    <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                FEED, DRAIN: begin
                    row_q <= (row_q == RW'(MATRIX_SIZE - 1)) ? '0 : row_q + 1'b1;
                    cyc_q <= cyc_q + 1'b1;
                    if (cyc_q == CW'(MATRIX_SIZE - 1)) begin
                        state_q <= DRAIN;
                    end
                    if (job_last_c) begin
                        cyc_q <= '0;
                        row_q <= '0;
                        if (swap_c) begin
                            state_q  <= FEED;
                            active_q <= ~active_q;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Per-port diagonal selection: port p walks M[r][r+d] with d = p - (MATRIX_SIZE-1).
    for (genvar p = 0; p < int'(ARRAY_SIZE); p++) begin : g_diag
        localparam int D    = p - int'(MATRIX_SIZE) + 1;
        localparam int R0   = (D < 0) ? -D : 0;
        localparam int LEN  = int'(MATRIX_SIZE) - ((D < 0) ? -D : D);
        localparam int BASE = R0 * (int'(MATRIX_SIZE) + 1) + D;

        logic          hit_c;
        logic [IW-1:0] idx_c;

        assign hit_c     = (state_q == FEED) && (cyc_q < CW'(LEN));
        assign idx_c     = IW'(BASE) + IW'(cyc_q) * IW'(MATRIX_SIZE + 1);
        assign left_d[p] = hit_c ? a_q[active_q][idx_c] : '0;
        assign top_d[p]  = hit_c ? b_q[active_q][idx_c] : '0;
    end

    // Registered stream outputs and strobes, one cycle behind the sequencer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_q     <= '0;
            top_q      <= '0;
            enable_q   <= 1'b0;
            row_done_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            left_q     <= left_d;
            top_q      <= top_d;
            enable_q   <= (state_q != IDLE);
            row_done_q <= (state_q != IDLE) && (row_q == RW'(MATRIX_SIZE - 1));
            done_q     <= (state_q == DRAIN) && job_last_c;
        end
    end

    // Lane-wise mapping between the unpacked ports and the packed internal vectors.
    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        assign load_vec_c[l]  = load_data[l];
        assign input_left0[l] = left_q[0][l];
        assign input_left1[l] = left_q[1][l];
        assign input_left2[l] = left_q[2][l];
        assign input_left3[l] = left_q[3][l];
        assign input_left4[l] = left_q[4][l];
        assign input_top0[l]  = top_q[0][l];
        assign input_top1[l]  = top_q[1][l];
        assign input_top2[l]  = top_q[2][l];
        assign input_top3[l]  = top_q[3][l];
        assign input_top4[l]  = top_q[4][l];
    end

    assign load_ready      = ~shadow_full_q;
    assign enable          = enable_q;
    assign is_row_done     = row_done_q;
    assign is_compute_done = done_q;
    assign busy            = busy_q;

endmodule
